// File: rtl/ibus_responder_pkg.sv
// Shared CPU definitions for the instruction-bus responder: FSM state type and
// memory response codes.
package ibus_responder_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    DATA      = 3'd2,
    ADDR_DROP = 3'd3,
    DATA_DROP = 3'd4
  } ibus_resp_state_t;

  localparam logic [1:0] MEM_RESP_OKAY = 2'b00;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ibus_responder_if.sv
// Fetch-side ibus handshake plus AXI-lite-style memory read channel.
// The slave modport is the responder; master is the surrounding fetch/memory side.
interface ibus_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  ibus_read;
  logic [ADDR_WIDTH-1:0] ibus_addr;
  logic                  ibus_ready;
  logic                  ibus_flush;
  logic                  ibus_valid;
  logic [DATA_WIDTH-1:0] ibus_rddata;
  logic                  ibus_err;

  logic                  mem_arvalid;
  logic [ADDR_WIDTH-1:0] mem_araddr;
  logic                  mem_arready;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [1:0]            mem_rresp;
  logic                  mem_rready;

  modport slave (
    input  ibus_read, ibus_addr, ibus_flush,
    input  mem_arready, mem_rvalid, mem_rdata, mem_rresp,
    output ibus_ready, ibus_valid, ibus_rddata, ibus_err,
    output mem_arvalid, mem_araddr, mem_rready
  );

  modport master (
    output ibus_read, ibus_addr, ibus_flush,
    output mem_arready, mem_rvalid, mem_rdata, mem_rresp,
    input  ibus_ready, ibus_valid, ibus_rddata, ibus_err,
    input  mem_arvalid, mem_araddr, mem_rready
  );
endinterface

// File: rtl/ibus_responder.sv
// Uncached ibus responder: one single-beat memory read per accepted fetch,
// flushable at any point while still completing the memory-side handshake.
module ibus_responder
  import ibus_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  ibus_responder_if.slave  bus
);

  ibus_resp_state_t      r_state, w_next;
  logic                  r_valid, r_err, r_arvalid, r_rready;
  logic [DATA_WIDTH-1:0] r_rddata;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  w_accept, w_aligned, w_rsp_take;

  assign w_aligned  = is_word_aligned(bus.ibus_addr[1:0]);
  assign w_accept   = (r_state == IDLE) & bus.ibus_read & ~bus.ibus_flush;
  assign w_rsp_take = (r_state == DATA) & bus.mem_rvalid & ~bus.ibus_flush;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_accept && w_aligned) w_next = ADDR;
      ADDR: begin
        if (bus.mem_arready)      w_next = bus.ibus_flush ? DATA_DROP : DATA;
        else if (bus.ibus_flush)  w_next = ADDR_DROP;
      end
      // A flush coinciding with rvalid completes the beat, so no drop state is needed.
      DATA: begin
        if (bus.mem_rvalid)       w_next = IDLE;
        else if (bus.ibus_flush)  w_next = DATA_DROP;
      end
      ADDR_DROP: if (bus.mem_arready) w_next = DATA_DROP;
      DATA_DROP: if (bus.mem_rvalid)  w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_rddata  <= '0;
      r_err     <= 1'b0;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_rready  <= 1'b0;
    end else begin
      r_state   <= w_next;
      // Memory-side strobes decode the next state so they are pure flops.
      r_arvalid <= (w_next == ADDR) || (w_next == ADDR_DROP);
      r_rready  <= (w_next == DATA) || (w_next == DATA_DROP);
      r_valid   <= 1'b0;
      if (w_accept && w_aligned) begin
        r_araddr <= {bus.ibus_addr[ADDR_WIDTH-1:2], 2'b00};
      end
      if (w_accept && !w_aligned) begin
        r_valid  <= 1'b1;
        r_rddata <= '0;
        r_err    <= 1'b1;
      end
      if (w_rsp_take) begin
        r_valid  <= 1'b1;
        r_rddata <= bus.mem_rdata;
        r_err    <= (bus.mem_rresp != MEM_RESP_OKAY);
      end
    end
  end

  assign bus.ibus_ready  = (r_state == IDLE);
  assign bus.ibus_valid  = r_valid;
  assign bus.ibus_rddata = r_rddata;
  assign bus.ibus_err    = r_err;
  assign bus.mem_arvalid = r_arvalid;
  assign bus.mem_araddr  = r_araddr;
  assign bus.mem_rready  = r_rready;

endmodule

// File: tb/tb_ibus_responder.sv
// Bench for ibus_responder: directed vector table, hand-written corner sequences,
// and a random run scored against a transaction-level model.
module tb_ibus_responder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ibus_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m ();

  ibus_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // fl: 0 none, 1 flush in first ADDR cycle, 2 flush with rvalid, 3 flush in DATA before rvalid
  typedef struct {
    logic [31:0] addr;
    int          ar_dly;
    int          r_dly;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          fl;
    bit          exp_v;
    logic [31:0] exp_d;
    bit          exp_e;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m.ibus_read   = 1'b0;
    m.ibus_addr   = '0;
    m.ibus_flush  = 1'b0;
    m.mem_arready = 1'b0;
    m.mem_rvalid  = 1'b0;
    m.mem_rdata   = '0;
    m.mem_rresp   = 2'b00;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit mis, rdone, done;
    int ar_w, r_w, rc, lat, npulse, arcnt, rrcnt;
    logic [31:0] gd;
    logic ge;
    mis = (v.addr[1:0] != 2'b00);
    rdone = 0; done = 0; ar_w = 0; r_w = 0; rc = 0; lat = 0;
    npulse = 0; arcnt = 0; rrcnt = 0; gd = '0; ge = 1'b0;
    @(negedge clk);
    m.ibus_read = 1'b1; m.ibus_addr = v.addr; m.ibus_flush = 1'b0;
    m.mem_arready = 1'b0; m.mem_rvalid = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      m.ibus_read = 1'b0;
      if (m.ibus_valid) begin npulse++; gd = m.ibus_rddata; ge = m.ibus_err; lat = c; end
      if (m.mem_arvalid) begin
        arcnt++;
        chk($sformatf("v%0d_araddr", idx), m.mem_araddr, {v.addr[31:2], 2'b00});
      end
      if (m.mem_rready) rrcnt++;
      if (!mis && !rdone) chk($sformatf("v%0d_busy_ready", idx), {31'b0, m.ibus_ready}, 32'd0);
      m.mem_arready = 1'b0; m.mem_rvalid = 1'b0; m.ibus_flush = 1'b0;
      if (m.mem_arvalid) begin
        if (ar_w == v.ar_dly) m.mem_arready = 1'b1; else ar_w++;
        if (v.fl == 1 && c == 1) m.ibus_flush = 1'b1;
      end else if (m.mem_rready && !rdone) begin
        if (r_w == v.r_dly) begin
          m.mem_rvalid = 1'b1; m.mem_rdata = v.rdata; m.mem_rresp = v.rresp;
          rdone = 1; rc = c;
          if (v.fl == 2) m.ibus_flush = 1'b1;
        end else begin
          if (v.fl == 3 && r_w == 0) m.ibus_flush = 1'b1;
          r_w++;
        end
      end
      if ((mis && c == 3) || (rdone && c == rc + 2)) done = 1;
    end
    chk($sformatf("v%0d_completed", idx), {31'b0, done}, 32'd1);
    chk($sformatf("v%0d_pulses", idx), npulse, v.exp_v ? 32'd1 : 32'd0);
    chk($sformatf("v%0d_arvalid_cycles", idx), arcnt, mis ? 0 : v.ar_dly + 1);
    chk($sformatf("v%0d_rready_cycles", idx), rrcnt, mis ? 0 : v.r_dly + 1);
    if (v.exp_v) begin
      chk($sformatf("v%0d_rddata", idx), gd, v.exp_d);
      chk($sformatf("v%0d_err", idx), {31'b0, ge}, {31'b0, v.exp_e});
      chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    end
    chk($sformatf("v%0d_ready_after", idx), {31'b0, m.ibus_ready}, 32'd1);
    idle_inputs();
  endtask

  // Transaction-level reference: busy between acceptance and the read beat,
  // address phase open until arready, any flush in between discards the response.
  task automatic run_random(input int ncyc);
    bit busy, arp, flushed, ev, ee;
    logic [31:0] laddr, ed, a;
    busy = 0; arp = 0; flushed = 0; ev = 0; ee = 0; laddr = '0; ed = '0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      @(negedge clk);
      chk("rnd_ready", {31'b0, m.ibus_ready}, {31'b0, !busy});
      chk("rnd_valid", {31'b0, m.ibus_valid}, {31'b0, ev});
      if (ev) begin
        chk("rnd_rddata", m.ibus_rddata, ed);
        chk("rnd_err", {31'b0, m.ibus_err}, {31'b0, ee});
      end
      chk("rnd_arvalid", {31'b0, m.mem_arvalid}, {31'b0, arp});
      if (arp) chk("rnd_araddr", m.mem_araddr, laddr);
      chk("rnd_rready", {31'b0, m.mem_rready}, {31'b0, busy && !arp});

      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      m.ibus_read   = ($urandom_range(0, 1) == 1);
      m.ibus_addr   = a;
      m.ibus_flush  = ($urandom_range(0, 9) == 0);
      m.mem_arready = arp && ($urandom_range(0, 2) == 0);
      m.mem_rvalid  = busy && !arp && ($urandom_range(0, 2) == 0);
      m.mem_rdata   = $urandom;
      m.mem_rresp   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;

      ev = 0;
      if (!busy) begin
        if (m.ibus_read && !m.ibus_flush) begin
          if (a[1:0] != 2'b00) begin ev = 1; ed = '0; ee = 1; end
          else begin busy = 1; arp = 1; flushed = 0; laddr = {a[31:2], 2'b00}; end
        end
      end else if (arp) begin
        if (m.ibus_flush) flushed = 1;
        if (m.mem_arready) arp = 0;
      end else if (m.mem_rvalid) begin
        if (!flushed && !m.ibus_flush) begin
          ev = 1; ed = m.mem_rdata; ee = (m.mem_rresp != 2'b00);
        end
        busy = 0;
      end else if (m.ibus_flush) begin
        flushed = 1;
      end
    end
    // let any final transaction drain so later activity starts from idle
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //          addr          ar r  rdata         rr    fl v  exp_d         e  lat
    vecs[0] = '{32'h1fc00000, 0, 0, 32'h3c1d8000, 2'b00, 0, 1, 32'h3c1d8000, 0, 3};
    vecs[1] = '{32'h1fc00010, 4, 3, 32'h8fbf0010, 2'b00, 0, 1, 32'h8fbf0010, 0, 10};
    vecs[2] = '{32'h1fc00020, 3, 2, 32'hdeadbeef, 2'b00, 1, 0, 32'h00000000, 0, 0};
    vecs[3] = '{32'h1fc00004, 0, 1, 32'h27bdffe8, 2'b00, 0, 1, 32'h27bdffe8, 0, 4};
    vecs[4] = '{32'h1fc00008, 1, 2, 32'hcafef00d, 2'b00, 2, 0, 32'h00000000, 0, 0};
    vecs[5] = '{32'h1fc0000c, 0, 3, 32'h0badf00d, 2'b00, 3, 0, 32'h00000000, 0, 0};
    vecs[6] = '{32'hbfc00100, 2, 0, 32'h12345678, 2'b10, 0, 1, 32'h12345678, 1, 5};
    vecs[7] = '{32'h1fc00002, 0, 0, 32'h55555555, 2'b00, 0, 1, 32'h00000000, 1, 1};
    vecs[8] = '{32'h1fc00003, 0, 0, 32'h55555555, 2'b00, 0, 1, 32'h00000000, 1, 1};
    vecs[9] = '{32'h00400040, 1, 1, 32'h0000abcd, 2'b01, 0, 1, 32'h0000abcd, 1, 5};

    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("rst_ready",   {31'b0, m.ibus_ready},  32'd1);
    chk("rst_valid",   {31'b0, m.ibus_valid},  32'd0);
    chk("rst_rddata",  m.ibus_rddata,          32'd0);
    chk("rst_err",     {31'b0, m.ibus_err},    32'd0);
    chk("rst_arvalid", {31'b0, m.mem_arvalid}, 32'd0);
    chk("rst_araddr",  m.mem_araddr,           32'd0);
    chk("rst_rready",  {31'b0, m.mem_rready},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // flush wins over a same-cycle request, aligned and misaligned
    @(negedge clk);
    m.ibus_read = 1'b1; m.ibus_addr = 32'h1fc00040; m.ibus_flush = 1'b1;
    @(negedge clk);
    m.ibus_addr = 32'h1fc00042;
    chk("flush_idle_arvalid", {31'b0, m.mem_arvalid}, 32'd0);
    chk("flush_idle_ready",   {31'b0, m.ibus_ready},  32'd1);
    @(negedge clk);
    idle_inputs();
    chk("flush_idle_valid", {31'b0, m.ibus_valid}, 32'd0);
    @(negedge clk);
    chk("flush_idle_valid2", {31'b0, m.ibus_valid}, 32'd0);

    // reset asserted while in the data phase
    m.ibus_read = 1'b1; m.ibus_addr = 32'h1fc00080;
    @(negedge clk);
    m.ibus_read = 1'b0; m.mem_arready = 1'b1;
    chk("rstdata_arvalid_pre", {31'b0, m.mem_arvalid}, 32'd1);
    @(negedge clk);
    m.mem_arready = 1'b0;
    chk("rstdata_rready_pre", {31'b0, m.mem_rready}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstdata_rready",  {31'b0, m.mem_rready},  32'd0);
    chk("rstdata_arvalid", {31'b0, m.mem_arvalid}, 32'd0);
    chk("rstdata_araddr",  m.mem_araddr,           32'd0);
    chk("rstdata_ready",   {31'b0, m.ibus_ready},  32'd1);
    chk("rstdata_valid",   {31'b0, m.ibus_valid},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstdata_no_pulse", {31'b0, m.ibus_valid}, 32'd0);
      chk("rstdata_ready_after", {31'b0, m.ibus_ready}, 32'd1);
    end
    run_vec(10, vecs[0]);

    run_random(4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibus_responder.md
# ibus_responder

Uncached instruction-bus responder: the memory-side end of the fetch-stage ibus handshake. Accepts one word-aligned physical fetch address at a time from the fetch stage, performs a single-beat read on the AXI-lite-style memory read channel, and returns the instruction word as a one-cycle `ibus_valid` pulse. Supports flush (branch redirect or exception) at any point without violating the memory-side handshake.

## Interface
- `DATA_WIDTH`, 32, instruction word width
- `ADDR_WIDTH`, 32, physical address width
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ibus_read`  in  1  fetch request valid
- `ibus_addr`  in  ADDR_WIDTH  physical fetch address
- `ibus_ready`  out  1  request accepted this cycle when high with `ibus_read`
- `ibus_flush`  in  1  discard current request/response
- `ibus_valid`  out  1  one-cycle response pulse, no backpressure
- `ibus_rddata`  out  DATA_WIDTH  instruction word, qualified by `ibus_valid`
- `ibus_err`  out  1  response is a bus error or misaligned fetch, qualified by `ibus_valid`
- `mem_arvalid`  out  1  read address valid
- `mem_araddr`  out  ADDR_WIDTH  read address (low 2 bits forced 0)
- `mem_arready`  in  1  read address accepted
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  DATA_WIDTH  read data
- `mem_rresp`  in  2  response code; nonzero = error
- `mem_rready`  out  1  read data accepted

## Operation
- States: IDLE, ADDR, DATA, ADDR_DROP, DATA_DROP.
- `ibus_ready` = (state == IDLE); combinational from state only.
- IDLE: `ibus_read & ~ibus_flush` with `ibus_addr[1:0]==0` -> latch address, ADDR. With `ibus_addr[1:0]!=0` -> no memory access; next cycle `ibus_valid=1`, `ibus_err=1`, `ibus_rddata=0`; stay IDLE.
- ADDR: `mem_arvalid=1`, `mem_araddr` stable. `mem_arready` -> DATA. `ibus_flush` without `mem_arready` -> ADDR_DROP; with `mem_arready` -> DATA_DROP.
- DATA: `mem_rready=1`. `mem_rvalid` -> next cycle `ibus_valid=1`, `ibus_rddata=mem_rdata`, `ibus_err=(mem_rresp!=0)`; IDLE. `ibus_flush` -> DATA_DROP (if `mem_rvalid` same cycle: data discarded, IDLE, no pulse).
- ADDR_DROP: `mem_arvalid` held (AXI rule) until `mem_arready` -> DATA_DROP.
- DATA_DROP: `mem_rready=1`; `mem_rvalid` -> IDLE, no `ibus_valid`.
- Flush in IDLE: no effect; flush wins over a same-cycle request (request not accepted, `ibus_ready` still high but ignored).
- Flush has no effect on a response already registered (pulse in flight on output); consumer discards it.
- At most one outstanding memory transaction.

## Timing
- Reset (async assert, sync-deasserted externally): state IDLE; `ibus_valid=0`, `ibus_rddata=0`, `ibus_err=0`, `mem_arvalid=0`, `mem_araddr=0`, `mem_rready=0`; `ibus_ready=1`.
- Reset mid-transaction: all state dropped immediately; memory side is reset by same `rst_n`.
- `mem_arvalid`, `mem_rready` registered-state decodes, no combinational path from `mem_*` inputs to `mem_*` outputs.
- Min latency: request sampled at edge N -> `mem_arvalid` in cycle N+1; `mem_arready` in N+1, `mem_rvalid` in N+2 -> `ibus_valid` in N+3. Next request acceptable in N+3.
- Misaligned fetch: `ibus_valid` one cycle after acceptance.
- `ibus_valid` high for exactly one cycle per accepted, unflushed request.

## Structure
- State enum `ibus_resp_state_t` and `MEM_RESP_OKAY` (2'b00) go in the shared CPU defs package alongside the ibus/pipe types.
- Single module, no sub-module; one `always_ff` for state + registered outputs, one `always_comb` for next state.

## Test plan
- Basic read: req 0x1fc00000, arready at N+1, rvalid rdata 0x3c1d8000 at N+2 -> `ibus_valid` at N+3 with 0x3c1d8000, `ibus_err=0`, `mem_araddr=0x1fc00000`.
- Stalled slave: arready delayed 4 cycles, rvalid 3 more -> `mem_arvalid`/`mem_araddr` stable throughout, single pulse, `ibus_ready` low until IDLE.
- Flush in ADDR without arready -> arvalid held until arready, rvalid consumed with `mem_rready=1`, no `ibus_valid`; next req 0x1fc00004 returns its own data.
- Flush same cycle as rvalid in DATA -> no pulse, IDLE next cycle, `ibus_ready=1`.
- Errors: `mem_rresp=2'b10` -> pulse with `ibus_err=1`; req 0x1fc00002 -> no `mem_arvalid`, pulse next cycle with `ibus_err=1`, `ibus_rddata=0`.
- `rst_n` low during DATA -> all outputs at reset values same cycle, `ibus_ready=1` after release, no stale pulse.
